ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares the single RAM port between two CPUs' caches (I and D requests each, 4 sources).
//  Sits between the caches and cpu_ram_if in the multicore top, alongside coherence control.
//  Grants one source at a time, holds the grant until the RAM returns ACCESS.
//  Round-robin between CPUs; data before instruction within a CPU; watchdog on stalled accesses.
// PARAMETERS
//  WORD_W   32   data width (word_t)
//  ADDR_W   32   address width
//  TIMEOUT  64   max cycles in BUSY before abort; 8-bit counter, legal 1..255
// PORTS
//  CLK        in   1       clock, rising edge
//  nRST       in   1       reset: synchronous, active-low
//  iREN       in   2       instruction read request, [c]=CPU c
//  dREN       in   2       data read request
//  dWEN       in   2       data write request
//  iaddr      in   2xADDR  instruction address per CPU
//  daddr      in   2xADDR  data address per CPU
//  dstore     in   2xWORD  write data per CPU
//  iwait      out  2       1 = CPU c's I request not yet done
//  dwait      out  2       1 = CPU c's D request not yet done
//  iload      out  2xWORD  read data to I side (= ramload)
//  dload      out  2xWORD  read data to D side (= ramload)
//  ramaddr    out  ADDR    RAM address
//  ramstore   out  WORD    RAM write data
//  ramREN     out  1       RAM read enable
//  ramWEN     out  1       RAM write enable
//  ramload    in   WORD    RAM read data
//  ramstate   in   2       FREE=0 BUSY=1 ACCESS=2 ERROR=3
//  tmo_err    out  1       1-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset (nRST=0 at edge): state=IDLE, owner=0, rr=0 (CPU0 favoured), cnt=0; all outputs
//   combinational from state: ramREN=ramWEN=0, ramaddr=ramstore=0, tmo_err=0.
//  iwait[c]=iREN[c] unless acked this cycle; dwait[c]=(dREN[c]|dWEN[c]) unless acked.
//  iload/dload drive ramload to all sides; meaningful only when matching wait=0.
//  Source order each IDLE cycle: D(rr), I(rr), D(~rr), I(~rr); first active one wins.
//  dWEN & dREN both set on one CPU: treated as write.
//  IDLE: if any request, register owner (cpu,src), go BUSY, cnt=0; no RAM access this cycle.
//  BUSY: ramaddr/ramstore/ramREN/ramWEN driven from owner's live inputs; cnt++ each cycle.
//   ramstate==ACCESS: owner's wait=0 this cycle (combinational ack), rr<=~owner.cpu, ->IDLE.
//   ramstate==ERROR: no ack, ->IDLE (re-arbitrate; rr unchanged).
//   owner withdraws request (enable low): ->IDLE, no ack, rr unchanged.
//   cnt==TIMEOUT-1 and no ACCESS: tmo_err=1 this cycle, no ack, ->IDLE, rr<=~owner.cpu.
//   FREE/BUSY otherwise: stay.
//  Latency: request at cycle t in IDLE -> RAM enables at t+1 -> ack in first ACCESS cycle;
//   min 2 cycles with ACCESS-on-first-cycle RAM. Non-owners keep wait=1 throughout.
//  Caches drop/advance request on the edge after ack; IDLE the next cycle re-arbitrates.
//  Reset mid-BUSY: access abandoned, no ack, enables low next cycle.
//  cnt saturates; never wraps while BUSY (exit forced at TIMEOUT-1).
// TESTING
//  Reset: nRST=0 w/ iREN=2'b11 -> ramREN=0, iwait=2'b11; release -> CPU0 I granted first.
//  Contention: dREN=2'b11, iREN=2'b11, ACCESS 1 cycle after each grant -> order
//   D0,D1,I0,I1 (rr alternates), each ack exactly one cycle, ramaddr matches owner.
//  Write: dWEN[1]=1, daddr[1]=0x40, dstore[1]=0xDEADBEEF -> ramWEN=1, ramaddr=0x40,
//   ramstore=0xDEADBEEF, dwait[1]=0 only in ACCESS cycle; dWEN&dREN -> ramWEN only.
//  Error/withdraw: ramstate=ERROR in BUSY -> IDLE, no ack, same source regranted;
//   owner drops REN mid-BUSY -> IDLE, enables low next cycle, rr unchanged.
//  Watchdog: TIMEOUT=4, ramstate held BUSY -> tmo_err pulse 4th BUSY cycle, IDLE, other CPU next.
//  Mid-op reset: assert nRST=0 during BUSY -> next cycle ramREN=ramWEN=0, no ack pulse.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-CPU, four-source arbiter for the shared RAM port
//
// Purpose: grants one of {D0, I0, D1, I1} at a time to the single RAM port.
//   The grant is held until the RAM reports ACCESS, ERROR, the owner withdraws,
//   or the watchdog expires. CPUs alternate in round-robin order, and within a
//   CPU the data side is served before the instruction side.
// Ports:
//   CLK, nRST            clock (rising edge), synchronous active-low reset
//   iREN, dREN, dWEN     per-CPU request enables, bit c = CPU c
//   iaddr, daddr, dstore per-CPU address/data, CPU c in slice [c*W +: W]
//   iwait, dwait         per-CPU "request not yet done"
//   iload, dload         ramload fanned out to every side
//   ramaddr, ramstore    RAM address / write data (owner's live inputs)
//   ramREN, ramWEN       RAM enables (owner's live inputs)
//   ramload, ramstate    RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   tmo_err              one-cycle pulse when the watchdog aborts an access
module ram_arbiter #(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [1:0]          iREN,
  input  logic [1:0]          dREN,
  input  logic [1:0]          dWEN,
  input  logic [2*ADDR_W-1:0] iaddr,
  input  logic [2*ADDR_W-1:0] daddr,
  input  logic [2*WORD_W-1:0] dstore,
  output logic [1:0]          iwait,
  output logic [1:0]          dwait,
  output logic [2*WORD_W-1:0] iload,
  output logic [2*WORD_W-1:0] dload,
  output logic [ADDR_W-1:0]   ramaddr,
  output logic [WORD_W-1:0]   ramstore,
  output logic                ramREN,
  output logic                ramWEN,
  input  logic [WORD_W-1:0]   ramload,
  input  logic [1:0]          ramstate,
  output logic                tmo_err
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic       own_cpu;   // CPU that holds the grant
  logic       own_d;     // 1 = data side, 0 = instruction side
  logic       rr;        // CPU favoured at the next arbitration
  logic [7:0] cnt;       // cycles spent in BUSY for the current grant

  logic grant_any, grant_cpu, grant_d;
  logic own_active, ack;
  logic [1:0] own_mask;

  // Fixed priority over the rotated source list D(rr), I(rr), D(~rr), I(~rr).
  always_comb begin
    grant_any = 1'b0;
    grant_cpu = rr;
    grant_d   = 1'b1;
    if (dREN[rr] | dWEN[rr]) begin
      grant_any = 1'b1; grant_cpu = rr;  grant_d = 1'b1;
    end else if (iREN[rr]) begin
      grant_any = 1'b1; grant_cpu = rr;  grant_d = 1'b0;
    end else if (dREN[~rr] | dWEN[~rr]) begin
      grant_any = 1'b1; grant_cpu = ~rr; grant_d = 1'b1;
    end else if (iREN[~rr]) begin
      grant_any = 1'b1; grant_cpu = ~rr; grant_d = 1'b0;
    end
  end

  // RAM side follows the owner's live inputs, so a withdrawn request drops
  // the enables in the same cycle. A write wins over a read on the D side.
  always_comb begin
    own_active = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    if (state == BUSY) begin
      if (own_d) begin
        own_active = dREN[own_cpu] | dWEN[own_cpu];
        ramaddr    = own_cpu ? daddr[2*ADDR_W-1:ADDR_W] : daddr[ADDR_W-1:0];
        ramstore   = own_cpu ? dstore[2*WORD_W-1:WORD_W] : dstore[WORD_W-1:0];
        ramWEN     = dWEN[own_cpu];
        ramREN     = dREN[own_cpu] & ~dWEN[own_cpu];
      end else begin
        own_active = iREN[own_cpu];
        ramaddr    = own_cpu ? iaddr[2*ADDR_W-1:ADDR_W] : iaddr[ADDR_W-1:0];
        ramREN     = iREN[own_cpu];
      end
    end
  end

  // A reset cycle abandons the access, so neither ack nor abort is reported.
  assign ack      = nRST & (state == BUSY) & own_active & (ramstate == RS_ACCESS);
  assign tmo_err  = nRST & (state == BUSY) & own_active & ~ack & (cnt == CNT_LAST);
  assign own_mask = own_cpu ? 2'b10 : 2'b01;

  assign iwait = iREN & ~(own_mask & {2{ack & ~own_d}});
  assign dwait = (dREN | dWEN) & ~(own_mask & {2{ack & own_d}});
  assign iload = {2{ramload}};
  assign dload = {2{ramload}};

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      own_cpu <= 1'b0;
      own_d   <= 1'b0;
      rr      <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state   <= BUSY;
            own_cpu <= grant_cpu;
            own_d   <= grant_d;
            cnt     <= '0;
          end
        end
        BUSY: begin
          if (!own_active || ack || tmo_err || ramstate == RS_ERROR)
            state <= IDLE;
          // Only a completed or aborted access hands priority to the other
          // CPU; errors and withdrawals re-arbitrate with the same favourite.
          if (ack || tmo_err)
            rr <= ~own_cpu;
          if (cnt != 8'hFF)
            cnt <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
